// File: rtl/tb_mem_arbiter_pkg.sv
// Shared definitions for the two-port test-memory arbiter: FSM encodings and port indices.
package tb_mem_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/tb_mem_arbiter_if.sv
// Requester (I/D) and memory-side bus of the test-memory arbiter.
interface tb_mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_ack;
  logic [DATA_W-1:0]     i_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W/8-1:0]   d_be;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_ack;
  logic [DATA_W-1:0]     d_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  // arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  // requesters + memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/tb_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that lost last time.
module rr_arb2
  import tb_mem_arb_defs::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt   = 2'b00;
    valid = |req;
    if (req == 2'b11) begin
      gnt[~last_grant] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/tb_mem_arbiter.sv
// Round-robin arbiter sharing one registered single-port memory between an I-fetch and a D port.
// state    | meaning
// ST_IDLE  | sample requests, grant one, latch its fields
// ST_ISSUE | drive memory strobe with latched fields
// ST_WAIT  | memory data valid, pulse winner's ack
module tb_mem_arbiter
  import tb_mem_arb_defs::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  tb_mem_arbiter_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] i_grants,
  output logic [CNT_W-1:0] d_grants
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        state, nxt_state;
  logic [1:0]        req, gnt;
  logic              gnt_valid;
  logic              last_grant;
  logic              win;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [BE_W-1:0]   lat_be;
  logic [DATA_W-1:0] lat_wdata;

  assign req = {bus.d_req, bus.i_req};

  rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt),
    .valid      (gnt_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= PORT_D;
      win        <= PORT_I;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_be     <= '0;
      lat_wdata  <= '0;
      i_grants   <= '0;
      d_grants   <= '0;
    end else begin
      state <= nxt_state;
      if (state == ST_IDLE && gnt_valid) begin
        win        <= gnt[PORT_D];
        last_grant <= gnt[PORT_D];
        if (gnt[PORT_D]) begin
          lat_we    <= bus.d_we;
          lat_addr  <= bus.d_addr;
          lat_be    <= bus.d_be;
          lat_wdata <= bus.d_wdata;
          if (d_grants != '1) d_grants <= d_grants + CNT_W'(1);
        end else begin
          lat_we    <= 1'b0;
          lat_addr  <= bus.i_addr;
          lat_be    <= '1;
          lat_wdata <= '0;
          if (i_grants != '1) i_grants <= i_grants + CNT_W'(1);
        end
      end
    end
  end

  // Outputs are qualified by reset so a transaction caught by reset neither strobes nor acks.
  always_comb begin
    nxt_state     = state;
    busy          = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    bus.i_ack     = 1'b0;
    bus.i_rdata   = '0;
    bus.d_ack     = 1'b0;
    bus.d_rdata   = '0;
    case (state)
      ST_IDLE: begin
        if (gnt_valid) nxt_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        nxt_state = ST_WAIT;
        if (reset) begin
          busy          = 1'b1;
          bus.mem_en    = 1'b1;
          bus.mem_we    = lat_we;
          bus.mem_addr  = lat_addr;
          bus.mem_be    = lat_be;
          bus.mem_wdata = lat_wdata;
        end
      end
      ST_WAIT: begin
        nxt_state = ST_IDLE;
        if (reset) begin
          busy = 1'b1;
          if (win == PORT_I) begin
            bus.i_ack   = 1'b1;
            bus.i_rdata = bus.mem_rdata;
          end else begin
            bus.d_ack   = 1'b1;
            bus.d_rdata = lat_we ? '0 : bus.mem_rdata;
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Randomized + directed bench for tb_mem_arbiter against a transaction-level reference model.
module tb_tb_mem_arbiter;
  import tb_mem_arb_defs::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tb_mem_arbiter_if #(.ADDR_W(6), .DATA_W(64)) bus ();
  tb_mem_arbiter_if #(.ADDR_W(6), .DATA_W(64)) bus2 ();
  logic        busy, busy2;
  logic [15:0] i_grants, d_grants;
  logic [1:0]  ig2, dg2;

  tb_mem_arbiter #(.ADDR_W(6), .DATA_W(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .i_grants(i_grants), .d_grants(d_grants));
  tb_mem_arbiter #(.ADDR_W(6), .DATA_W(64), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2), .busy(busy2), .i_grants(ig2), .d_grants(dg2));

  function automatic logic [63:0] init_val(int a);
    return 64'h1000_0000_0000_0001 * 64'(a + 1);
  endfunction

  // memories: registered read, byte-enabled write
  logic [63:0] ram [64];
  logic [63:0] ram2 [64];
  initial begin
    for (int a = 0; a < 64; a++) begin
      ram[a]  = init_val(a);
      ram2[a] = init_val(a);
    end
    bus.mem_rdata  = '0;
    bus2.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we)
          for (int b = 0; b < 8; b++)
            if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        bus.mem_rdata <= ram[bus.mem_addr];
      end
      if (bus2.mem_en) begin
        if (bus2.mem_we)
          for (int b = 0; b < 8; b++)
            if (bus2.mem_be[b]) ram2[bus2.mem_addr][8*b +: 8] <= bus2.mem_wdata[8*b +: 8];
        bus2.mem_rdata <= ram2[bus2.mem_addr];
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state (transaction level)
  logic [63:0] sh [64];
  int          g_cyc = -100;
  int          next_free = 0;
  logic        g_port, g_we, m_last;
  logic [5:0]  g_addr;
  logic [7:0]  g_be;
  logic [63:0] g_wdata;
  int          m_icnt, m_dcnt;

  // observations for directed pins
  typedef struct {int c; logic p;} ack_t;
  ack_t        ack_q[$];
  logic        i_ack_last, d_ack_last, i2_ack_last;
  logic [63:0] last_i_rdata, last_d_rdata, last_i2_rdata;
  logic [7:0]  last_mem_be;
  int          last_en_cyc, last_i_ack_cyc;
  int          first_ack_cyc = -1;
  logic        first_ack_port;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    logic issue, ack;
    i_ack_last  = bus.i_ack;
    d_ack_last  = bus.d_ack;
    i2_ack_last = bus2.i_ack;
    if (bus2.i_ack) last_i2_rdata = bus2.i_rdata;
    if (bus.mem_en) begin last_en_cyc = cyc; last_mem_be = bus.mem_be; end
    if (bus.i_ack) begin
      last_i_ack_cyc = cyc; last_i_rdata = bus.i_rdata;
      ack_q.push_back('{cyc, PORT_I});
    end
    if (bus.d_ack) begin
      last_d_rdata = bus.d_rdata;
      ack_q.push_back('{cyc, PORT_D});
    end
    if (first_ack_cyc < 0 && (bus.i_ack || bus.d_ack)) begin
      first_ack_cyc = cyc; first_ack_port = bus.d_ack;
    end
    if (!reset) begin
      chk("rst_i_ack", bus.i_ack, 0);       chk("rst_d_ack", bus.d_ack, 0);
      chk("rst_mem_en", bus.mem_en, 0);     chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0); chk("rst_mem_be", bus.mem_be, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_i_rdata", bus.i_rdata, 0);   chk("rst_d_rdata", bus.d_rdata, 0);
      next_free = cyc + 1; g_cyc = -100; m_last = PORT_D; m_icnt = 0; m_dcnt = 0;
      return;
    end
    chk("i_grants", i_grants, 64'(m_icnt));
    chk("d_grants", d_grants, 64'(m_dcnt));
    chk("busy", busy, cyc < next_free);
    issue = (cyc == g_cyc + 1);
    ack   = (cyc == g_cyc + 2);
    chk("mem_en", bus.mem_en, issue);
    chk("mem_we", bus.mem_we, issue ? g_we : 1'b0);
    chk("mem_addr", bus.mem_addr, issue ? g_addr : 6'd0);
    chk("mem_be", bus.mem_be, issue ? g_be : 8'd0);
    if (!issue || g_we) chk("mem_wdata", bus.mem_wdata, issue ? g_wdata : 64'd0);
    if (issue && g_we)
      for (int b = 0; b < 8; b++)
        if (g_be[b]) sh[g_addr][8*b +: 8] = g_wdata[8*b +: 8];
    chk("i_ack", bus.i_ack, ack && g_port == PORT_I);
    chk("d_ack", bus.d_ack, ack && g_port == PORT_D);
    if (ack && !g_we) begin
      if (g_port == PORT_I) chk("i_rdata", bus.i_rdata, sh[g_addr]);
      else                  chk("d_rdata", bus.d_rdata, sh[g_addr]);
    end
    if (cyc >= next_free && (bus.i_req || bus.d_req)) begin
      g_port = (bus.i_req && bus.d_req) ? ~m_last : bus.d_req;
      m_last = g_port; g_cyc = cyc; next_free = cyc + 3;
      if (g_port == PORT_D) begin
        g_we = bus.d_we; g_addr = bus.d_addr; g_be = bus.d_be; g_wdata = bus.d_wdata;
        if (m_dcnt < 65535) m_dcnt++;
      end else begin
        g_we = 1'b0; g_addr = bus.i_addr; g_be = 8'hFF; g_wdata = '0;
        if (m_icnt < 65535) m_icnt++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic i_read(input logic [5:0] a);
    logic ok;
    ok = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = a;
    for (int t = 0; t < 20; t++) begin
      step();
      if (i_ack_last) begin ok = 1'b1; break; end
    end
    bus.i_req = 1'b0;
    chk("i_read_ack", ok, 1);
  endtask

  task automatic d_xfer(input logic we, input logic [5:0] a, input logic [7:0] be, input logic [63:0] wd);
    logic ok;
    ok = 1'b0;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_be = be; bus.d_wdata = wd;
    for (int t = 0; t < 20; t++) begin
      step();
      if (d_ack_last) begin ok = 1'b1; break; end
    end
    bus.d_req = 1'b0;
    chk("d_xfer_ack", ok, 1);
  endtask

  initial begin
    int   rel, ic0, dc0, i_wait, d_wait;
    logic ok2;
    for (int a = 0; a < 64; a++) sh[a] = init_val(a);
    bus.i_req = 1'b1; bus.i_addr = 6'd7;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd9; bus.d_be = 8'hFF; bus.d_wdata = '0;
    bus2.i_req = 1'b0; bus2.i_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
    bus2.d_addr = '0; bus2.d_be = '0; bus2.d_wdata = '0;
    reset = 1'b0;

    // reset with both requesting, then release: I must win first
    step(); step();
    reset = 1'b1;
    rel = cyc;
    chk("rel_i_grants", i_grants, 0);
    chk("rel_d_grants", d_grants, 0);
    for (int t = 0; t < 30 && (bus.i_req || bus.d_req); t++) begin
      step();
      if (i_ack_last) bus.i_req = 1'b0;
      if (d_ack_last) bus.d_req = 1'b0;
    end
    chk("rel_drain", {bus.i_req, bus.d_req}, 0);
    chk("first_ack_port", first_ack_port, PORT_I);
    chk("first_ack_cyc", 64'(first_ack_cyc), 64'(rel + 2));

    // I read of a known word
    d_xfer(1'b1, 6'd5, 8'hFF, 64'h0123456789ABCDEF);
    ic0 = int'(i_grants);
    i_read(6'd5);
    chk("i_read_data", last_i_rdata, 64'h0123456789ABCDEF);
    chk("i_read_cnt", i_grants, 64'(ic0 + 1));
    chk("i_read_lat", 64'(last_i_ack_cyc - last_en_cyc), 1);

    // D partial write and readback
    d_xfer(1'b1, 6'd3, 8'hFF, 64'h0);
    d_xfer(1'b1, 6'd3, 8'h0F, 64'hFFFFFFFF_AABBCCDD);
    chk("d_wr_be", last_mem_be, 8'h0F);
    d_xfer(1'b0, 6'd3, 8'hFF, 64'h0);
    chk("d_rd_data", last_d_rdata, 64'h00000000_AABBCCDD);

    // contention: both held for 12 cycles
    ic0 = int'(i_grants); dc0 = int'(d_grants);
    ack_q.delete();
    bus.i_req = 1'b1; bus.i_addr = 6'd5;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd3; bus.d_be = 8'hFF;
    repeat (12) step();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk("cont_nacks", 64'(ack_q.size()), 4);
    for (int k = 0; k < ack_q.size(); k++) begin
      chk("cont_port", ack_q[k].p, (k % 2 == 1) ? PORT_D : PORT_I);
      if (k > 0) chk("cont_gap", 64'(ack_q[k].c - ack_q[k-1].c), 3);
    end
    chk("cont_icnt", i_grants, 64'(ic0 + 2));
    chk("cont_dcnt", d_grants, 64'(dc0 + 2));

    // reset while in WAIT aborts the read
    ack_q.delete();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd4; bus.d_be = 8'hFF;
    step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1; bus.d_req = 1'b0;
    chk("mid_noack", 64'(ack_q.size()), 0);
    chk("mid_busy", busy, 0);
    chk("mid_mem_en", bus.mem_en, 0);
    chk("mid_icnt", i_grants, 0);
    chk("mid_dcnt", d_grants, 0);

    // reset while in ISSUE: the write must not land
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd6; bus.d_be = 8'hFF;
    bus.d_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1; bus.d_req = 1'b0;
    d_xfer(1'b0, 6'd6, 8'hFF, 64'h0);
    chk("issue_rst_data", last_d_rdata, 64'h7000_0000_0000_0007);

    // randomized traffic with occasional resets
    i_wait = 0; d_wait = 0;
    for (int n = 0; n < 600; n++) begin
      step();
      reset = ($urandom_range(60) != 0);
      if (bus.i_req) begin
        if (i_ack_last) begin
          i_wait = 0;
          if ($urandom_range(1) == 1) bus.i_addr = 6'($urandom_range(7));
          else bus.i_req = 1'b0;
        end else if (++i_wait > 20) begin
          chk("rand_i_wait", 64'(i_wait), 20);
          bus.i_req = 1'b0; i_wait = 0;
        end
      end else if ($urandom_range(2) == 0) begin
        bus.i_req = 1'b1; bus.i_addr = 6'($urandom_range(7)); i_wait = 0;
      end
      if (bus.d_req) begin
        if (d_ack_last) begin
          d_wait = 0;
          bus.d_req = ($urandom_range(1) == 1);
        end else if (++d_wait > 20) begin
          chk("rand_d_wait", 64'(d_wait), 20);
          bus.d_req = 1'b0; d_wait = 0;
        end
      end else if ($urandom_range(2) == 0) begin
        bus.d_req = 1'b1; d_wait = 0;
      end
      if (bus.d_req && d_wait == 0) begin
        bus.d_we = 1'($urandom_range(1)); bus.d_addr = 6'($urandom_range(7));
        bus.d_be = 8'($urandom); bus.d_wdata = {$urandom, $urandom};
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0; reset = 1'b1;
    repeat (5) step();

    // saturating counter on the 2-bit instance
    for (int n = 1; n <= 5; n++) begin
      ok2 = 1'b0;
      bus2.i_req = 1'b1; bus2.i_addr = 6'(n);
      for (int t = 0; t < 10; t++) begin
        step();
        if (i2_ack_last) begin ok2 = 1'b1; break; end
      end
      bus2.i_req = 1'b0;
      chk("sat_ack", ok2, 1);
      chk("sat_rdata", last_i2_rdata, init_val(n));
      chk("sat_cnt", ig2, (n >= 3) ? 64'd3 : 64'(n));
    end
    step();
    chk("sat_dcnt", dg2, 0);
    chk("sat_busy", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tb_mem_arbiter.md
# tb_mem_arbiter

Two-port round-robin arbiter that shares the single-port 64-bit test memory between the CPU instruction-fetch port and the data port in the `tb_mr_cpu_top` simulation harness. It accepts one outstanding request per port, serialises them onto the memory, returns read data with a per-port acknowledge, and keeps saturating per-port grant counters for bench diagnostics.

## Interface
Parameters:
- `ADDR_W`, 6: doubleword index width (64-entry memory).
- `DATA_W`, 64: memory data width.
- `CNT_W`, 16: grant counter width.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `i_req`  in  1  instruction-fetch request, read-only.
- `i_addr`  in  ADDR_W  fetch doubleword index.
- `i_ack`  out  1  one-cycle completion pulse for the I port.
- `i_rdata`  out  DATA_W  fetch data, valid while `i_ack` is high.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_W  data doubleword index.
- `d_be`  in  DATA_W/8  write byte enables; bit n covers data bits [8n+7:8n].
- `d_wdata`  in  DATA_W  write data.
- `d_ack`  out  1  one-cycle completion pulse for the D port.
- `d_rdata`  out  DATA_W  read data, valid while `d_ack` is high. It is undefined on a write ack.
- `mem_en`, `mem_we`  out  1  memory strobe and write enable.
- `mem_addr`  out  ADDR_W.
- `mem_be`  out  DATA_W/8.
- `mem_wdata`  out  DATA_W.
- `mem_rdata`  in  DATA_W  memory read data, registered, valid the cycle after `mem_en`.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `i_grants`, `d_grants`  out  CNT_W  saturating grant counters.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - Samples `i_req` and `d_req`.
  - If neither is high, stays in IDLE.
  - Otherwise it picks a winner and latches that port's addr, we, be and wdata. The I port always latches we=0 and be=all-ones.
  - Increments the winner's grant counter, holding at all-ones when already saturated.
  - Goes to ISSUE.
- **Arbitration**
  - A single requester always wins.
  - If both request, the winner is the port that did not win the last grant (`last_grant` register).
  - `last_grant` updates on every grant.
  - `last_grant` resets to D, so I wins the first contended cycle after reset.
- **ISSUE**
  - Drives `mem_en`=1 and the latched `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`.
  - Goes to WAIT.
- **WAIT**
  - Pulses the winner's ack.
  - For a read, the winner's rdata equals `mem_rdata` in this cycle. For the I port it is always a read.
  - Goes to IDLE.
- **Requester rules**
  - Hold req and all fields stable from assertion until ack.
  - Requests are sampled only in IDLE.
  - A req still high in the cycle after ack is a new request.
- **Outputs**
  - Memory outputs are zero when `mem_en`=0.
  - Acks are never high simultaneously.
  - A loser keeps waiting and is served by the next IDLE.
- **Reset values**
  - State IDLE; `last_grant`=D; counters 0.
  - All outputs 0: acks, `mem_en`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `busy`, rdata.
- **Reset mid-operation**
  - Reset in ISSUE or WAIT aborts the transaction: no ack is issued.
  - A memory write already strobed in ISSUE has taken effect. One not yet strobed does not.

## Timing
- req seen in IDLE at cycle N → `mem_en` at N+1 → ack and rdata at N+2 → IDLE at N+3.
- Fixed latency is 2 cycles from grant. Peak throughput is one access per 3 cycles.
- Both ports continuously requesting → grants alternate I, D, I, D… One access every 3 cycles, each port's ack every 6.
- `busy` is registered: high at N+1 and N+2.

## Structure
- Shared package / include `tb_mem_arb_defs`:
  - state encodings `ST_IDLE`/`ST_ISSUE`/`ST_WAIT`;
  - port index constants `PORT_I`=0, `PORT_D`=1.
- One sub-module, `rr_arb2`:
  - inputs: two request bits and `last_grant`;
  - outputs: one-hot grant plus valid;
  - purely combinational.
- Counters, latches and FSM live in the top module.

## Test plan
- Reset:
  - hold `reset`=0 for 2 cycles with both reqs high → all outputs 0, no ack, counters 0;
  - release → I granted first, `i_ack` at grant+2.
- I read:
  - preload `mem[5]`=64'h0123456789ABCDEF;
  - `i_req` with `i_addr`=5 → `mem_en` one cycle after grant, then `i_ack` with `i_rdata`=64'h0123456789ABCDEF;
  - `i_grants`=1.
- D partial write then read:
  - write `d_addr`=3, `d_be`=8'h0F, `d_wdata`=64'hFFFFFFFF_AABBCCDD over `mem[3]`=0 → `mem_be`=8'h0F;
  - read back → `d_rdata`=64'h00000000_AABBCCDD.
- Contention:
  - both reqs held high for 12 cycles → acks strictly alternate I, D, I, D, 3 cycles apart;
  - never both high;
  - counters 2/2.
- Reset mid-op:
  - assert `reset` in WAIT → no ack that cycle, FSM IDLE, `mem_en`=0, counters 0.
- Saturation:
  - `CNT_W`=2, 5 I reads → `i_grants` stays 2'b11.
